mem_lsu: RTL and testbench
==========================

// Module: mem_lsu
// PURPOSE
//  MEM stage; sits directly downstream of the execute stage.
//  Takes the write-back triple (wd, wreg, wdata) plus the memory op from EX.
//  Runs byte, half and word loads/stores on a req/ack data bus and stalls the pipe until ack.
//  Presents the registered MEM/WB result to write-back.
// PARAMETERS
//  DBUS_TIMEOUT  256  cycles in WAIT without ack before err_o pulses and the op is dropped; 0 = no timeout
// PORTS
//  clk         in   1   clock; all state changes on the rising edge
//  rst         in   1   asynchronous, active-low reset
//  aluop_i     in   8   op code from EX; EXE_LB/LBU/LH/LHU/LW/SB/SH/SW_OP are memory ops
//  wd_i        in   5   destination register from EX
//  wreg_i      in   1   write enable from EX
//  wdata_i     in   32  ALU result from EX; passed through for non-memory ops
//  mem_addr_i  in   32  effective address
//  reg2_i      in   32  store data
//  flush_i     in   1   squash the current MEM instruction
//  stallreq_o  out  1   combinational; high while a memory op is unfinished
//  dbus_req_o  out  1   registered request; held until ack
//  dbus_we_o   out  1   1 = store
//  dbus_addr_o out  32  word address {addr[31:2],2'b00}
//  dbus_sel_o  out  4   byte-lane enables
//  dbus_wdata_o out 32  store data replicated across lanes
//  dbus_rdata_i in  32  read data; valid with ack
//  dbus_ack_i  in   1   one-cycle completion pulse
//  wd_o        out  5   to WB (registered)
//  wreg_o      out  1   to WB (registered)
//  wdata_o     out  32  to WB (registered)
//  err_o       out  1   one-cycle pulse on timeout or misalignment
// BEHAVIOUR
//  Reset: all outputs 0; FSM = IDLE; counters cleared.
//   Reset is async, so dbus_req_o drops at once even mid-transaction.
//  FSM: IDLE -> WAIT -> DONE -> IDLE.
//   IDLE: non-memory op -> register inputs to WB every cycle (stallreq_o=0).
//         Memory op -> stallreq_o=1, latch bus fields, go to WAIT.
//   WAIT: dbus_req_o=1, stallreq_o=1.
//         On ack: capture aligned and extended rdata, go to DONE.
//   DONE: stallreq_o=0; the result loads into the WB regs at this edge; go to IDLE.
//  While stalled, WB regs take a bubble (wreg_o=0, wd_o=0, wdata_o=0).
//  Latency: ack in the first WAIT cycle puts the load result on wdata_o 3 edges after it enters MEM.
//  Stores write nothing back (wreg_o forced 0).
//  Lanes are big-endian, offset = addr[1:0].
//   Byte: sel = 4'b1000 >> offset.
//   Half: sel = 1100 or 0011, chosen by addr[1].
//   Word: sel = 1111.
//  Loads: LB/LH sign-extend; LBU/LHU zero-extend.
//  ack outside WAIT is ignored.
//  A new op is accepted in the cycle after DONE (the IDLE cycle).
//  flush_i in IDLE/DONE: WB regs get a bubble.
//  flush_i in WAIT: sets a drop flag; the bus op finishes on ack, the result is discarded; the flag clears in IDLE.
//  ack and flush_i in the same WAIT cycle: the result is discarded.
//  Timeout: the counter saturates at DBUS_TIMEOUT; then err_o pulses, req drops, WB gets a bubble, FSM -> IDLE.
// CONFIGURATION
//  MEM_ALIGN_EXC_EN defined: a half with addr[0]=1 or a word with addr[1:0]!=0 issues no bus op.
//   err_o pulses, WB gets a bubble, and stallreq_o stays 0.
//  MEM_ALIGN_EXC_EN undefined: the low address bits that cause misalignment are forced to 0.
// STRUCTURE
//  defines.v: the EXE_*_OP memory op codes, the MEM FSM state encodings, and widths (RegBus, RegAddrBus, AluOpBus).
//  One sub-module, mem_align: combinational lane select, store replication, load extract and extend.
// TESTING
//  1. LW addr 0x100, ack 1 cycle after req, rdata 0xDEADBEEF
//     -> sel=1111, stall 2 cycles, wdata_o=0xDEADBEEF, wreg_o=1.
//  2. LB addr 0x103, rdata 0x000000F0 -> sel=0001, wdata_o=0xFFFFFFF0.
//     LBU same -> wdata_o=0x000000F0.
//  3. SH addr 0x102, reg2 0x1234 -> we=1, sel=0011, wdata=0x12341234, wreg_o=0.
//  4. flush_i during WAIT, ack 3 cycles later -> req held until ack, then a bubble; the next op runs normally.
//  5. No ack for DBUS_TIMEOUT=4 cycles -> err_o pulse, req low, FSM IDLE.
//  6. LW addr 0x102, macro on -> err_o=1, no req.
//     Macro off -> addr 0x100, sel=1111.

Source files
------------

// File: rtl/mem_lsu_pkg.sv
// Shared definitions for the MEM stage: op codes, bus widths, FSM states and
// small decode helpers used by both mem_lsu and mem_align.
package mem_lsu_pkg;

    localparam int RegBus     = 32;
    localparam int RegAddrBus = 5;
    localparam int AluOpBus   = 8;

    localparam logic [AluOpBus-1:0] EXE_LB_OP  = 8'b1110_0000;
    localparam logic [AluOpBus-1:0] EXE_LH_OP  = 8'b1110_0001;
    localparam logic [AluOpBus-1:0] EXE_LW_OP  = 8'b1110_0011;
    localparam logic [AluOpBus-1:0] EXE_LBU_OP = 8'b1110_0100;
    localparam logic [AluOpBus-1:0] EXE_LHU_OP = 8'b1110_0101;
    localparam logic [AluOpBus-1:0] EXE_SB_OP  = 8'b1110_1000;
    localparam logic [AluOpBus-1:0] EXE_SH_OP  = 8'b1110_1001;
    localparam logic [AluOpBus-1:0] EXE_SW_OP  = 8'b1110_1011;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_WAIT = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_e;

    typedef enum logic [1:0] {
        SZ_NONE = 2'd0,
        SZ_BYTE = 2'd1,
        SZ_HALF = 2'd2,
        SZ_WORD = 2'd3
    } mem_size_e;

    function automatic logic is_load(input logic [AluOpBus-1:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP, EXE_LW_OP: is_load = 1'b1;
            default: is_load = 1'b0;
        endcase
    endfunction

    function automatic logic is_store(input logic [AluOpBus-1:0] op);
        case (op)
            EXE_SB_OP, EXE_SH_OP, EXE_SW_OP: is_store = 1'b1;
            default: is_store = 1'b0;
        endcase
    endfunction

    function automatic logic is_mem_op(input logic [AluOpBus-1:0] op);
        is_mem_op = is_load(op) || is_store(op);
    endfunction

    function automatic mem_size_e op_size(input logic [AluOpBus-1:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: op_size = SZ_BYTE;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: op_size = SZ_HALF;
            EXE_LW_OP, EXE_SW_OP:             op_size = SZ_WORD;
            default:                          op_size = SZ_NONE;
        endcase
    endfunction

    function automatic logic is_misaligned(input logic [AluOpBus-1:0] op, input logic [1:0] off);
        case (op_size(op))
            SZ_HALF: is_misaligned = off[0];
            SZ_WORD: is_misaligned = (off != 2'b00);
            default: is_misaligned = 1'b0;
        endcase
    endfunction

    // Clears the offset bits that would make a half or word access straddle lanes.
    function automatic logic [1:0] force_offset(input logic [AluOpBus-1:0] op, input logic [1:0] off);
        case (op_size(op))
            SZ_HALF: force_offset = {off[1], 1'b0};
            SZ_WORD: force_offset = 2'b00;
            default: force_offset = off;
        endcase
    endfunction

endpackage

// File: rtl/mem_lsu_align.sv
// mem_align: combinational big-endian lane logic -- byte enables, store data
// replication, and load byte/half extraction with sign or zero extension.
module mem_align
    import mem_lsu_pkg::*;
(
    input  logic [AluOpBus-1:0] aluop_i,
    input  logic [1:0]          offset_i,
    input  logic [RegBus-1:0]   reg2_i,
    input  logic [RegBus-1:0]   rdata_i,
    output logic [3:0]          sel_o,
    output logic [RegBus-1:0]   wdata_o,
    output logic [RegBus-1:0]   rdata_o
);

    logic [1:0]  off;
    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        off     = force_offset(aluop_i, offset_i);
        sel_o   = 4'b0000;
        wdata_o = '0;
        rdata_o = '0;

        // Offset 0 is the most significant lane.
        case (off)
            2'd0:    byte_v = rdata_i[31:24];
            2'd1:    byte_v = rdata_i[23:16];
            2'd2:    byte_v = rdata_i[15:8];
            default: byte_v = rdata_i[7:0];
        endcase
        half_v = off[1] ? rdata_i[15:0] : rdata_i[31:16];

        case (op_size(aluop_i))
            SZ_BYTE: begin
                sel_o   = 4'b1000 >> off;
                wdata_o = {4{reg2_i[7:0]}};
            end
            SZ_HALF: begin
                sel_o   = off[1] ? 4'b0011 : 4'b1100;
                wdata_o = {2{reg2_i[15:0]}};
            end
            SZ_WORD: begin
                sel_o   = 4'b1111;
                wdata_o = reg2_i;
            end
            default: ;
        endcase

        case (aluop_i)
            EXE_LB_OP:  rdata_o = {{24{byte_v[7]}}, byte_v};
            EXE_LBU_OP: rdata_o = {24'd0, byte_v};
            EXE_LH_OP:  rdata_o = {{16{half_v[15]}}, half_v};
            EXE_LHU_OP: rdata_o = {16'd0, half_v};
            EXE_LW_OP:  rdata_o = rdata_i;
            default:    rdata_o = '0;
        endcase
    end

endmodule

// File: rtl/mem_lsu.sv
// MEM stage load/store unit: drives a req/ack data bus, stalls the pipe until
// ack, and registers the MEM/WB triple. Optional feature macro: MEM_ALIGN_EXC_EN.
module mem_lsu
    import mem_lsu_pkg::*;
#(
    parameter int unsigned DBUS_TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [AluOpBus-1:0]   aluop_i,
    input  logic [RegAddrBus-1:0] wd_i,
    input  logic                  wreg_i,
    input  logic [RegBus-1:0]     wdata_i,
    input  logic [RegBus-1:0]     mem_addr_i,
    input  logic [RegBus-1:0]     reg2_i,
    input  logic                  flush_i,
    output logic                  stallreq_o,
    output logic                  dbus_req_o,
    output logic                  dbus_we_o,
    output logic [RegBus-1:0]     dbus_addr_o,
    output logic [3:0]            dbus_sel_o,
    output logic [RegBus-1:0]     dbus_wdata_o,
    input  logic [RegBus-1:0]     dbus_rdata_i,
    input  logic                  dbus_ack_i,
    output logic [RegAddrBus-1:0] wd_o,
    output logic                  wreg_o,
    output logic [RegBus-1:0]     wdata_o,
    output logic                  err_o,
    output mem_state_e            dbg_state_o
);

    mem_state_e            state_q, state_d;
    logic [AluOpBus-1:0]   op_q, op_d;
    logic [RegBus-1:0]     addr_q, addr_d;
    logic [RegBus-1:0]     reg2_q, reg2_d;
    logic [RegAddrBus-1:0] wdh_q, wdh_d;
    logic                  wregh_q, wregh_d;
    logic                  req_q, req_d;
    logic                  drop_q, drop_d;
    logic [31:0]           cnt_q, cnt_d;
    logic [RegBus-1:0]     res_q, res_d;
    logic                  err_q, err_d;
    logic [RegAddrBus-1:0] wd_q, wd_d;
    logic                  wreg_q, wreg_d;
    logic [RegBus-1:0]     wdata_q, wdata_d;
    logic [RegBus-1:0]     ld_data;
    logic                  misal;
    logic                  timeout_hit;

    mem_align u_align (
        .aluop_i  (op_q),
        .offset_i (addr_q[1:0]),
        .reg2_i   (reg2_q),
        .rdata_i  (dbus_rdata_i),
        .sel_o    (dbus_sel_o),
        .wdata_o  (dbus_wdata_o),
        .rdata_o  (ld_data)
    );

    always_comb begin
`ifdef MEM_ALIGN_EXC_EN
        misal = is_misaligned(aluop_i, mem_addr_i[1:0]);
`else
        misal = 1'b0;
`endif
        timeout_hit = (DBUS_TIMEOUT != 0) && !dbus_ack_i && (cnt_q == DBUS_TIMEOUT - 1);
    end

    // Next state and outputs. WB registers default to a bubble every cycle.
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        addr_d     = addr_q;
        reg2_d     = reg2_q;
        wdh_d      = wdh_q;
        wregh_d    = wregh_q;
        req_d      = req_q;
        drop_d     = drop_q;
        cnt_d      = cnt_q;
        res_d      = res_q;
        err_d      = 1'b0;
        wd_d       = '0;
        wreg_d     = 1'b0;
        wdata_d    = '0;
        stallreq_o = 1'b0;

        case (state_q)
            MEM_IDLE: begin
                drop_d = 1'b0;
                cnt_d  = '0;
                if (flush_i) begin
                    wd_d = '0;
                end else if (!is_mem_op(aluop_i)) begin
                    wd_d    = wd_i;
                    wreg_d  = wreg_i;
                    wdata_d = wdata_i;
                end else if (misal) begin
                    err_d = 1'b1;
                end else begin
                    stallreq_o = 1'b1;
                    op_d       = aluop_i;
                    addr_d     = mem_addr_i;
                    reg2_d     = reg2_i;
                    wdh_d      = wd_i;
                    wregh_d    = wreg_i;
                    req_d      = 1'b1;
                    state_d    = MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                stallreq_o = 1'b1;
                if (flush_i) begin
                    drop_d = 1'b1;
                end
                if (dbus_ack_i) begin
                    res_d   = ld_data;
                    req_d   = 1'b0;
                    state_d = MEM_DONE;
                end else if (timeout_hit) begin
                    // Release the pipe now so the dead op leaves MEM instead of re-issuing.
                    stallreq_o = 1'b0;
                    err_d      = 1'b1;
                    req_d      = 1'b0;
                    state_d    = MEM_IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + 32'd1;
                end
            end
            MEM_DONE: begin
                if (!drop_q && !flush_i && is_load(op_q)) begin
                    wd_d    = wdh_q;
                    wreg_d  = wregh_q;
                    wdata_d = res_q;
                end
                state_d = MEM_IDLE;
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op_q    <= '0;
            addr_q  <= '0;
            reg2_q  <= '0;
            wdh_q   <= '0;
            wregh_q <= 1'b0;
            req_q   <= 1'b0;
            drop_q  <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            err_q   <= 1'b0;
            wd_q    <= '0;
            wreg_q  <= 1'b0;
            wdata_q <= '0;
        end else begin
            op_q    <= op_d;
            addr_q  <= addr_d;
            reg2_q  <= reg2_d;
            wdh_q   <= wdh_d;
            wregh_q <= wregh_d;
            req_q   <= req_d;
            drop_q  <= drop_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
            err_q   <= err_d;
            wd_q    <= wd_d;
            wreg_q  <= wreg_d;
            wdata_q <= wdata_d;
        end
    end

    assign dbus_req_o  = req_q;
    assign dbus_we_o   = is_store(op_q);
    assign dbus_addr_o = {addr_q[31:2], 2'b00};
    assign wd_o        = wd_q;
    assign wreg_o      = wreg_q;
    assign wdata_o     = wdata_q;
    assign err_o       = err_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_mem_lsu.sv
// Bench for mem_lsu: directed cases plus randomized instruction/bus traffic,
// checked every cycle against a transaction-level model of the MEM stage.
module tb_mem_lsu;
    import mem_lsu_pkg::*;

    localparam int TB_TIMEOUT = 4;

    // ---------------- clock / reset ----------------
    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  aluop_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [31:0] wdata_i, mem_addr_i, reg2_i, dbus_rdata_i;
    logic        flush_i, dbus_ack_i;
    logic        stallreq_o, dbus_req_o, dbus_we_o, wreg_o, err_o;
    logic [31:0] dbus_addr_o, dbus_wdata_o, wdata_o;
    logic [3:0]  dbus_sel_o;
    logic [4:0]  wd_o;
    mem_state_e  dbg_state;

    always #5 clk = ~clk;

    mem_lsu #(.DBUS_TIMEOUT(TB_TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .aluop_i      (aluop_i),
        .wd_i         (wd_i),
        .wreg_i       (wreg_i),
        .wdata_i      (wdata_i),
        .mem_addr_i   (mem_addr_i),
        .reg2_i       (reg2_i),
        .flush_i      (flush_i),
        .stallreq_o   (stallreq_o),
        .dbus_req_o   (dbus_req_o),
        .dbus_we_o    (dbus_we_o),
        .dbus_addr_o  (dbus_addr_o),
        .dbus_sel_o   (dbus_sel_o),
        .dbus_wdata_o (dbus_wdata_o),
        .dbus_rdata_i (dbus_rdata_i),
        .dbus_ack_i   (dbus_ack_i),
        .wd_o         (wd_o),
        .wreg_o       (wreg_o),
        .wdata_o      (wdata_o),
        .err_o        (err_o),
        .dbg_state_o  (dbg_state)
    );

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic        stall;
        logic        req;
        logic        we;
        logic [31:0] addr;
        logic [3:0]  sel;
        logic [31:0] bwd;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] wdata;
        logic        err;
    } exp_t;

    logic [$bits(exp_t)-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // What the registered WB/err outputs must show in the cycle being pushed.
    logic [4:0]  wb_wd    = '0;
    logic        wb_wreg  = 1'b0;
    logic [31:0] wb_wdata = '0;
    logic        wb_err   = 1'b0;

    int          obs_stall, obs_req;
    logic [3:0]  obs_sel;
    logic        obs_we;
    logic [31:0] obs_addr, obs_bwd;

    logic [7:0] ops [8] = '{EXE_LB_OP, EXE_LBU_OP, EXE_LH_OP, EXE_LHU_OP,
                            EXE_LW_OP, EXE_SB_OP, EXE_SH_OP, EXE_SW_OP};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        exp_t r;
        if (exp_q.size() != 0) begin
            r = exp_t'(exp_q.pop_front());
            chk("stallreq", 32'(stallreq_o), 32'(r.stall));
            chk("dbus_req", 32'(dbus_req_o), 32'(r.req));
            chk("wd",       32'(wd_o),       32'(r.wd));
            chk("wreg",     32'(wreg_o),     32'(r.wreg));
            chk("wdata",    wdata_o,         r.wdata);
            chk("err",      32'(err_o),      32'(r.err));
            if (r.req) begin
                chk("dbus_we",    32'(dbus_we_o),  32'(r.we));
                chk("dbus_addr",  dbus_addr_o,     r.addr);
                chk("dbus_sel",   32'(dbus_sel_o), 32'(r.sel));
                chk("dbus_wdata", dbus_wdata_o,    r.bwd);
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic int op_bytes(input logic [7:0] op);
        case (op)
            EXE_LB_OP, EXE_LBU_OP, EXE_SB_OP: return 1;
            EXE_LH_OP, EXE_LHU_OP, EXE_SH_OP: return 2;
            EXE_LW_OP, EXE_SW_OP:             return 4;
            default:                          return 0;
        endcase
    endfunction

    function automatic logic op_is_load(input logic [7:0] op);
        return (op == EXE_LB_OP) || (op == EXE_LBU_OP) || (op == EXE_LH_OP) ||
               (op == EXE_LHU_OP) || (op == EXE_LW_OP);
    endfunction

    function automatic logic op_is_signed(input logic [7:0] op);
        return (op == EXE_LB_OP) || (op == EXE_LH_OP);
    endfunction

    function automatic logic op_misal(input logic [7:0] op, input logic [31:0] a);
        return (a % op_bytes(op)) != 0;
    endfunction

    function automatic logic [31:0] eff_addr(input logic [7:0] op, input logic [31:0] a);
        return a - (a % op_bytes(op));
    endfunction

    // Big-endian: the byte at offset o sits on lane bit 3-o.
    function automatic logic [3:0] model_sel(input logic [7:0] op, input logic [31:0] a);
        int nb = op_bytes(op);
        int off = int'(a % 4);
        logic [3:0] mask = 4'((1 << nb) - 1);
        return mask << (4 - nb - off);
    endfunction

    function automatic logic [31:0] model_bwd(input logic [7:0] op, input logic [31:0] d);
        case (op_bytes(op))
            1:       return 32'(d[7:0]) * 32'h0101_0101;
            2:       return 32'(d[15:0]) * 32'h0001_0001;
            default: return d;
        endcase
    endfunction

    function automatic logic [31:0] model_load(input logic [7:0] op, input logic [31:0] a,
                                               input logic [31:0] rd);
        int nb = op_bytes(op);
        int off = int'(a % 4);
        logic [31:0] mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
        logic [31:0] v = (rd >> (8 * (4 - nb - off))) & mask;
        if (op_is_signed(op) && v[8*nb-1]) v = v | ~mask;
        return v;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        #1;
        if (stallreq_o) obs_stall++;
        if (dbus_req_o) obs_req++;
    endtask

    task automatic garbage_bus();
        dbus_ack_i   = 1'($urandom_range(0, 1));
        dbus_rdata_i = $urandom();
    endtask

    task automatic push(input logic stall, input logic req, input logic we,
                        input logic [31:0] addr, input logic [3:0] sel, input logic [31:0] bwd);
        exp_t r;
        r.stall = stall;
        r.req   = req;
        r.we    = we;
        r.addr  = addr;
        r.sel   = sel;
        r.bwd   = bwd;
        r.wd    = wb_wd;
        r.wreg  = wb_wreg;
        r.wdata = wb_wdata;
        r.err   = wb_err;
        exp_q.push_back(r);
    endtask

    task automatic set_wb(input logic [4:0] wd, input logic wreg, input logic [31:0] wdata,
                          input logic err);
        wb_wd    = wd;
        wb_wreg  = wreg;
        wb_wdata = wdata;
        wb_err   = err;
    endtask

    task automatic run_alu(input logic flush);
        step();
        aluop_i    = 8'($urandom_range(0, 8'hDF));
        wd_i       = 5'($urandom());
        wreg_i     = 1'($urandom());
        wdata_i    = $urandom();
        mem_addr_i = $urandom();
        reg2_i     = $urandom();
        flush_i    = flush;
        garbage_bus();
        push(1'b0, 1'b0, 1'b0, '0, '0, '0);
        sample();
        if (flush) set_wb('0, 1'b0, '0, 1'b0);
        else       set_wb(wd_i, wreg_i, wdata_i, 1'b0);
    endtask

    task automatic run_mem(input logic [7:0] op, input logic [31:0] addr, input logic [31:0] reg2,
                           input logic [31:0] rdata, input logic [4:0] wd, input logic wreg,
                           input int ack_dly, input int flush_at, input logic flush_done,
                           input logic flush_idle);
        logic        mis, dropped, timed_out, st;
        logic [31:0] ea;
        int          n;
        obs_stall = 0;
        obs_req   = 0;
        obs_sel   = '0;
        obs_we    = 1'b0;
        obs_addr  = '0;
        obs_bwd   = '0;
`ifdef MEM_ALIGN_EXC_EN
        mis = op_misal(op, addr);
`else
        mis = 1'b0;
`endif
        ea = eff_addr(op, addr);
        st = !op_is_load(op);

        step();
        aluop_i    = op;
        mem_addr_i = addr;
        reg2_i     = reg2;
        wd_i       = wd;
        wreg_i     = wreg;
        wdata_i    = $urandom();
        flush_i    = flush_idle;
        garbage_bus();
        if (flush_idle || mis) begin
            push(1'b0, 1'b0, 1'b0, '0, '0, '0);
            sample();
            set_wb('0, 1'b0, '0, mis && !flush_idle);
            return;
        end
        push(1'b1, 1'b0, 1'b0, '0, '0, '0);
        sample();
        set_wb('0, 1'b0, '0, 1'b0);

        timed_out = ack_dly > TB_TIMEOUT;
        n         = timed_out ? TB_TIMEOUT : ack_dly;
        dropped   = 1'b0;
        for (int k = 1; k <= n; k++) begin
            step();
            flush_i      = (k == flush_at);
            dbus_ack_i   = (k == ack_dly);
            dbus_rdata_i = dbus_ack_i ? rdata : $urandom();
            dropped      = dropped | flush_i;
            push(!(timed_out && k == n), 1'b1, st, ea & 32'hFFFF_FFFC,
                 model_sel(op, ea), model_bwd(op, reg2));
            sample();
            if (k == 1) begin
                obs_sel  = dbus_sel_o;
                obs_we   = dbus_we_o;
                obs_addr = dbus_addr_o;
                obs_bwd  = dbus_wdata_o;
            end
        end

        if (timed_out) begin
            set_wb('0, 1'b0, '0, 1'b1);
            return;
        end
        step();
        flush_i = flush_done;
        garbage_bus();
        push(1'b0, 1'b0, 1'b0, '0, '0, '0);
        sample();
        if (!st && !dropped && !flush_done) set_wb(wd, wreg, model_load(op, ea, rdata), 1'b0);
        else                                set_wb('0, 1'b0, '0, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst          = 1'b0;
        aluop_i      = '0;
        wd_i         = '0;
        wreg_i       = 1'b0;
        wdata_i      = '0;
        mem_addr_i   = '0;
        reg2_i       = '0;
        flush_i      = 1'b0;
        dbus_ack_i   = 1'b0;
        dbus_rdata_i = '0;
        #1;
        chk("reset_req",   32'(dbus_req_o), 32'd0);
        chk("reset_stall", 32'(stallreq_o), 32'd0);
        chk("reset_we",    32'(dbus_we_o),  32'd0);
        chk("reset_sel",   32'(dbus_sel_o), 32'd0);
        chk("reset_addr",  dbus_addr_o,     32'd0);
        chk("reset_wdata", wdata_o,         32'd0);
        chk("reset_wreg",  32'(wreg_o),     32'd0);
        chk("reset_err",   32'(err_o),      32'd0);
        chk("reset_state", 32'(dbg_state),  32'(MEM_IDLE));
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;

        // LW, ack in the first WAIT cycle
        run_mem(EXE_LW_OP, 32'h100, 32'h0, 32'hDEADBEEF, 5'd3, 1'b1, 1, 0, 1'b0, 1'b0);
        chk("t1_sel",   32'(obs_sel), 32'hF);
        chk("t1_stall", 32'(obs_stall), 32'd2);
        run_alu(1'b0);
        chk("t1_wdata", wdata_o, 32'hDEADBEEF);
        chk("t1_wreg",  32'(wreg_o), 32'd1);

        run_mem(EXE_LB_OP, 32'h103, 32'h0, 32'h0000_00F0, 5'd4, 1'b1, 2, 0, 1'b0, 1'b0);
        chk("t2_sel", 32'(obs_sel), 32'h1);
        run_alu(1'b0);
        chk("t2_lb", wdata_o, 32'hFFFF_FFF0);
        run_mem(EXE_LBU_OP, 32'h103, 32'h0, 32'h0000_00F0, 5'd4, 1'b1, 1, 0, 1'b0, 1'b0);
        run_alu(1'b0);
        chk("t2_lbu", wdata_o, 32'h0000_00F0);

        run_mem(EXE_SH_OP, 32'h102, 32'h1234, 32'h0, 5'd5, 1'b1, 1, 0, 1'b0, 1'b0);
        chk("t3_we",   32'(obs_we), 32'd1);
        chk("t3_sel",  32'(obs_sel), 32'h3);
        chk("t3_bwd",  obs_bwd, 32'h1234_1234);
        run_alu(1'b0);
        chk("t3_wreg", 32'(wreg_o), 32'd0);

        // flush in the first WAIT cycle, ack three cycles later
        run_mem(EXE_LW_OP, 32'h104, 32'h0, 32'h1111_2222, 5'd6, 1'b1, 4, 1, 1'b0, 1'b0);
        chk("t4_req_cycles", 32'(obs_req), 32'd4);
        run_alu(1'b0);
        chk("t4_wreg",  32'(wreg_o), 32'd0);
        chk("t4_wdata", wdata_o, 32'd0);
        run_mem(EXE_LW_OP, 32'h108, 32'h0, 32'hCAFE_F00D, 5'd7, 1'b1, 1, 0, 1'b0, 1'b0);
        run_alu(1'b0);
        chk("t4_next", wdata_o, 32'hCAFE_F00D);

        // no ack at all
        run_mem(EXE_LW_OP, 32'h10C, 32'h0, 32'h0, 5'd8, 1'b1, 100, 0, 1'b0, 1'b0);
        chk("t5_req_cycles", 32'(obs_req), 32'(TB_TIMEOUT));
        run_alu(1'b0);
        chk("t5_err",   32'(err_o), 32'd1);
        chk("t5_req",   32'(dbus_req_o), 32'd0);
        chk("t5_state", 32'(dbg_state), 32'(MEM_IDLE));

        run_mem(EXE_LW_OP, 32'h102, 32'h0, 32'h0BAD_F00D, 5'd9, 1'b1, 1, 0, 1'b0, 1'b0);
`ifdef MEM_ALIGN_EXC_EN
        chk("t6_req",   32'(obs_req), 32'd0);
        chk("t6_stall", 32'(obs_stall), 32'd0);
        run_alu(1'b0);
        chk("t6_err",   32'(err_o), 32'd1);
`else
        chk("t6_addr",  obs_addr, 32'h100);
        chk("t6_sel",   32'(obs_sel), 32'hF);
        run_alu(1'b0);
        chk("t6_wdata", wdata_o, 32'h0BAD_F00D);
`endif

        for (int i = 0; i < 200; i++) begin
            if ($urandom_range(0, 1) == 1) begin
                run_alu($urandom_range(0, 9) == 0);
            end else begin
                run_mem(ops[$urandom_range(0, 7)], $urandom(), $urandom(), $urandom(),
                        5'($urandom()), 1'($urandom()),
                        ($urandom_range(0, 9) == 0) ? TB_TIMEOUT + 1
                                                    : int'($urandom_range(1, TB_TIMEOUT)),
                        ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, TB_TIMEOUT)) : 0,
                        $urandom_range(0, 9) == 0, $urandom_range(0, 19) == 0);
            end
        end
        run_alu(1'b0);

        // async reset in the middle of a bus op
        step();
        aluop_i    = EXE_LW_OP;
        mem_addr_i = 32'h200;
        flush_i    = 1'b0;
        dbus_ack_i = 1'b0;
        step();
        dbus_ack_i = 1'b0;
        #1;
        chk("arst_pre_req", 32'(dbus_req_o), 32'd1);
        rst = 1'b0;
        #1;
        chk("arst_req",   32'(dbus_req_o), 32'd0);
        chk("arst_state", 32'(dbg_state),  32'(MEM_IDLE));
        chk("arst_wreg",  32'(wreg_o),     32'd0);
        chk("arst_err",   32'(err_o),      32'd0);
        #20;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
